// File: rtl/dmem_responder_if.sv
// dmem_responder_if: store/load port between the core (master) and the data-memory responder (slave).
// Signals: memwrite/memread requests, dataadr byte address, writedata store data,
// readdata load data, ready one-cycle completion, busy, sticky addr_err/pass/fail,
// store_count (only when DMEM_STORE_CNT_EN is defined).
interface dmem_if;
    logic        memwrite;
    logic        memread;
    logic [63:0] dataadr;
    logic [63:0] writedata;
    logic [63:0] readdata;
    logic        ready;
    logic        busy;
    logic        addr_err;
    logic        pass;
    logic        fail;
`ifdef DMEM_STORE_CNT_EN
    logic [15:0] store_count;
    modport master (output memwrite, memread, dataadr, writedata,
                    input readdata, ready, busy, addr_err, pass, fail, store_count);
    modport slave (input memwrite, memread, dataadr, writedata,
                   output readdata, ready, busy, addr_err, pass, fail, store_count);
`else
    modport master (output memwrite, memread, dataadr, writedata,
                    input readdata, ready, busy, addr_err, pass, fail);
    modport slave (input memwrite, memread, dataadr, writedata,
                   output readdata, ready, busy, addr_err, pass, fail);
`endif
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder with sticky pass/fail/addr_err self-check flags.
// Ports: clk (rising edge), reset (sync, active-high), bus (dmem_if.slave: memwrite, memread,
// dataadr, writedata in; readdata, ready, busy, addr_err, pass, fail out).
// Optional: DMEM_STORE_CNT_EN adds bus.store_count, a saturating count of completed stores.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int PASS_ADDR   = 20,
    parameter int PASS_DATA   = 1000,
    parameter int IGNORE_ADDR = 80
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0]  WL = 4'(WAIT_CYCLES - 1);
    localparam logic [63:0] PA = 64'(PASS_ADDR);
    localparam logic [63:0] PD = 64'(PASS_DATA);
    localparam logic [63:0] IA = 64'(IGNORE_ADDR);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        req, accept, resp, err;
    logic        op_w;
    logic [63:0] adr, wd;
    logic [63:0] readdata_q;
    logic        ready_q, busy_q, addr_err_q, pass_q, fail_q;
    logic [63:0] mem [DEPTH];
    logic [AW-1:0] idx;
    assign req    = bus.memwrite | bus.memread;
    assign accept = (state == S_IDLE) && req;
    assign resp   = (state == S_RESP);
    assign idx    = adr[AW+1:2];
    assign err    = adr[63:AW+2] != '0;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: if (req) begin
                state_n = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                cnt_n   = WL;
            end
            S_WAIT: begin
                cnt_n   = cnt - 4'd1;
                state_n = (cnt == 4'd0) ? S_RESP : S_WAIT;
            end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            readdata_q <= '0;
            addr_err_q <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            op_w       <= 1'b0;
            adr        <= '0;
            wd         <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            // busy stays high through the ready cycle, dropping only if IDLE sees no new request
            busy_q  <= (state == S_IDLE) ? req : 1'b1;
            ready_q <= resp;
            if (accept) begin
                op_w <= bus.memwrite;
                adr  <= bus.dataadr;
                wd   <= bus.writedata;
            end
            if (resp) begin
                if (err) addr_err_q <= 1'b1;
                if (!op_w) readdata_q <= err ? '0 : mem[idx];
                if (op_w && adr == PA) begin
                    if (wd == PD) pass_q <= 1'b1;
                    else fail_q <= 1'b1;
                end else if (op_w && adr != IA) begin
                    fail_q <= 1'b1;
                end
            end
        end
    end
    // backing store is never cleared; a store aborted by reset never reaches it
    always_ff @(posedge clk) begin
        if (!reset && resp && op_w && !err) mem[idx] <= wd;
    end
    assign bus.readdata = readdata_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.addr_err = addr_err_q;
    assign bus.pass     = pass_q;
    assign bus.fail     = fail_q;
`ifdef DMEM_STORE_CNT_EN
    logic [15:0] sc;
    always_ff @(posedge clk) begin
        if (reset) sc <= '0;
        else if (resp && op_w && sc != 16'hFFFF) sc <= sc + 16'd1;
    end
    assign bus.store_count = sc;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven plus directed checks of dmem_responder at WAIT_CYCLES=2 and 0.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    dmem_if b0();
    dmem_if b1();
    dmem_responder #(.WAIT_CYCLES(2)) u0 (.clk(clk), .reset(reset), .bus(b0));
    dmem_responder #(.WAIT_CYCLES(0)) u1 (.clk(clk), .reset(reset), .bus(b1));
    int tests = 0;
    int fails = 0;
    int sc = 0;
    int lat;
    typedef struct {
        bit          rst;
        bit          w;
        logic [63:0] a;
        logic [63:0] d;
        int          lat;
        logic [63:0] rd;
        bit          p;
        bit          f;
        bit          e;
    } vec_t;
    vec_t tv[15];
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask
    task automatic drive(input bit s, input logic w, input logic r, input logic [63:0] a, input logic [63:0] d);
        if (s) begin
            b1.memwrite = w; b1.memread = r; b1.dataadr = a; b1.writedata = d;
        end else begin
            b0.memwrite = w; b0.memread = r; b0.dataadr = a; b0.writedata = d;
        end
    endtask
    task automatic wait_ready(input bit s, output int l);
        bit rdy = 0;
        l = 0;
        for (int i = 1; i <= 20 && !rdy; i++) begin
            @(posedge clk); #1;
            if (s ? b1.ready : b0.ready) begin
                rdy = 1;
                l = i;
            end
        end
        chk("ready_seen", 64'(rdy), 64'd1);
    endtask
    task automatic xact(input bit s, input bit w, input logic [63:0] a, input logic [63:0] d, output int l);
        drive(s, w, !w, a, d);
        @(posedge clk); #1;
        drive(s, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5A5A_5A5A_5A5A_5A5A);
        wait_ready(s, l);
        if (w && !s && l != 0) sc++;
    endtask
    task automatic idle_chk(input bit s);
        @(posedge clk); #1;
        chk("idle_busy", 64'(s ? b1.busy : b0.busy), 64'd0);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sc = 0;
    endtask
    initial begin
        tv[0]  = '{1, 1, 64'd20,  64'd1000,   3, 64'd0,      1, 0, 0};
        tv[1]  = '{0, 1, 64'd80,  64'd7,      3, 64'd0,      1, 0, 0};
        tv[2]  = '{0, 0, 64'd20,  64'd0,      3, 64'd1000,   1, 0, 0};
        tv[3]  = '{0, 1, 64'd84,  64'd5,      3, 64'd1000,   1, 1, 0};
        tv[4]  = '{0, 1, 64'd20,  64'd1000,   3, 64'd1000,   1, 1, 0};
        tv[5]  = '{0, 1, 64'd8,   64'hDEAD,   3, 64'd1000,   1, 1, 0};
        tv[6]  = '{0, 0, 64'd8,   64'd0,      3, 64'hDEAD,   1, 1, 0};
        tv[7]  = '{1, 1, 64'd20,  64'd42,     3, 64'd0,      0, 1, 0};
        tv[8]  = '{0, 1, 64'd0,   64'd55,     3, 64'd0,      0, 1, 0};
        tv[9]  = '{0, 0, 64'd8,   64'd0,      3, 64'hDEAD,   0, 1, 0};
        tv[10] = '{0, 0, 64'd256, 64'd0,      3, 64'd0,      0, 1, 1};
        tv[11] = '{0, 1, 64'd256, 64'd777,    3, 64'd0,      0, 1, 1};
        tv[12] = '{0, 0, 64'd0,   64'd0,      3, 64'd55,     0, 1, 1};
        tv[13] = '{1, 0, 64'h1_0000_0008, 64'd0, 3, 64'd0,   0, 0, 1};
        tv[14] = '{1, 0, 64'd84,  64'd0,      3, 64'd5,      0, 0, 0};
        do_reset();
        chk("rst_readdata", b0.readdata, 64'd0);
        chk("rst_flags", {59'd0, b0.ready, b0.busy, b0.addr_err, b0.pass, b0.fail}, 64'd0);
        chk("rst_flags_w0", {59'd0, b1.ready, b1.busy, b1.addr_err, b1.pass, b1.fail}, 64'd0);
`ifdef DMEM_STORE_CNT_EN
        chk("rst_store_count", 64'(b0.store_count), 64'd0);
`endif
        repeat (3) idle_chk(0);
        for (int i = 0; i < 15; i++) begin
            if (tv[i].rst) do_reset();
            xact(0, tv[i].w, tv[i].a, tv[i].d, lat);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(tv[i].lat));
            chk($sformatf("v%0d_readdata", i), b0.readdata, tv[i].rd);
            chk($sformatf("v%0d_busy", i), 64'(b0.busy), 64'd1);
            chk($sformatf("v%0d_pfe", i), {61'd0, b0.pass, b0.fail, b0.addr_err}, {61'd0, tv[i].p, tv[i].f, tv[i].e});
`ifdef DMEM_STORE_CNT_EN
            chk($sformatf("v%0d_store_count", i), 64'(b0.store_count), 64'(sc));
`endif
            idle_chk(0);
        end
        // reset during WAIT aborts a store at 16
        do_reset();
        xact(0, 1, 64'd16, 64'h1111, lat);
        idle_chk(0);
        drive(0, 1, 0, 64'd16, 64'h2222);
        @(posedge clk); #1;
        chk("abort_busy", 64'(b0.busy), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        begin
            bit seen = 0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                if (b0.ready) seen = 1;
            end
            chk("abort_no_ready", 64'(seen), 64'd0);
        end
        reset = 1'b0;
        sc = 0;
        xact(0, 0, 64'd16, 64'd0, lat);
        chk("abort_lat", 64'(lat), 64'd3);
        chk("abort_readdata", b0.readdata, 64'h1111);
        chk("abort_fail", 64'(b0.fail), 64'd0);
`ifdef DMEM_STORE_CNT_EN
        chk("abort_store_count", 64'(b0.store_count), 64'd0);
`endif
        idle_chk(0);
        // back-to-back: load held across ready is accepted again
        drive(0, 0, 1, 64'd16, 64'd0);
        @(posedge clk); #1;
        wait_ready(0, lat);
        chk("b2b_lat1", 64'(lat), 64'd3);
        chk("b2b_rd1", b0.readdata, 64'h1111);
        wait_ready(0, lat);
        drive(0, 0, 0, 0, 0);
        chk("b2b_lat2", 64'(lat), 64'd4);
        chk("b2b_rd2", b0.readdata, 64'h1111);
        idle_chk(0);
        // zero wait states
        xact(1, 1, 64'd40, 64'd9, lat);
        chk("w0_store_lat", 64'(lat), 64'd1);
        chk("w0_busy", 64'(b1.busy), 64'd1);
        chk("w0_fail", 64'(b1.fail), 64'd1);
        idle_chk(1);
        xact(1, 0, 64'd40, 64'd0, lat);
        chk("w0_load_lat", 64'(lat), 64'd1);
        chk("w0_readdata", b1.readdata, 64'd9);
        idle_chk(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
